// File: rtl/sramlike_axi_bridge.sv
// -----------------------------------------------------------------------------
// sramlike_axi_bridge
//
// Serves the CPU's stall-style instruction-fetch port and data-memory port.
// Each request becomes one single-beat AXI4 read or write on a shared master
// interface. Only one transaction is in flight at a time. Data requests win
// arbitration over fetches. A completed result is held, with its stall low,
// until the pipeline advances (longest_stall == 0).
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   longest_stall       pipeline-wide stall; low means the pipeline advances
//   inst_*              fetch port: req/addr in, rdata/stall out
//   data_*              data port: req/wr/size/addr/wdata in, rdata/stall out
//   ar*/r*              AXI read address / read data channels
//   aw*/w*/b*           AXI write address / write data / write response
// -----------------------------------------------------------------------------
module sramlike_axi_bridge #(
  parameter bit         ADDR_MAP = 1'b1,
  parameter logic [3:0] INST_ID  = 4'd0,
  parameter logic [3:0] DATA_ID  = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        longest_stall,
  // fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RD_ADDR     = 3'd1,
    RD_DATA     = 3'd2,
    WR_ADDRDATA = 3'd3,
    WR_RESP     = 3'd4
  } state_e;

  state_e      state_q;
  logic        owner_data_q;   // 1: in-flight read belongs to the data port
  logic        inst_done_q;
  logic        data_done_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        rready_q;
  logic        awvalid_q;
  logic [3:0]  awid_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        wvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bready_q;

  // kseg0/kseg1 fold onto physical low memory; everything else is untranslated.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    logic [31:0] m;
    if (ADDR_MAP && (a[31:30] == 2'b10)) begin
      m = {3'b000, a[28:0]};
    end else begin
      m = a;
    end
    return m;
  endfunction

  // size 3 is not a legal request; it is issued as a word and left to the
  // exception logic to flag.
  function automatic logic [2:0] axi_size(input logic [1:0] s);
    logic [2:0] r;
    if (s == 2'd3) begin
      r = 3'd2;
    end else begin
      r = {1'b0, s};
    end
    return r;
  endfunction

  // Byte-lane strobe; store data arrives already shifted into its lanes.
  function automatic logic [3:0] strobe(input logic [1:0] s, input logic [1:0] a);
    logic [3:0] r;
    case (s)
      2'd0:    r = 4'b0001 << a;
      2'd1:    r = a[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Request FSM, AXI channel registers, done flags and result holding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      arvalid_q    <= 1'b0;
      arid_q       <= 4'd0;
      araddr_q     <= 32'd0;
      arsize_q     <= 3'd0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awid_q       <= 4'd0;
      awaddr_q     <= 32'd0;
      awsize_q     <= 3'd0;
      wvalid_q     <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      bready_q     <= 1'b0;
    end else begin
      // Pipeline advance retires both held results. A done flag set later in
      // this block overrides the clear: that port was still stalling, so the
      // pipeline cannot really have advanced past it.
      if (!longest_stall) begin
        inst_done_q <= 1'b0;
        data_done_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (data_req && !data_done_q) begin
            owner_data_q <= 1'b1;
            if (data_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awid_q    <= DATA_ID;
              awaddr_q  <= map_addr(data_addr);
              awsize_q  <= axi_size(data_size);
              wdata_q   <= data_wdata;
              wstrb_q   <= strobe(data_size, data_addr[1:0]);
              state_q   <= WR_ADDRDATA;
            end else begin
              arvalid_q <= 1'b1;
              arid_q    <= DATA_ID;
              araddr_q  <= map_addr(data_addr);
              arsize_q  <= axi_size(data_size);
              state_q   <= RD_ADDR;
            end
          end else if (inst_req && !inst_done_q) begin
            owner_data_q <= 1'b0;
            arvalid_q    <= 1'b1;
            arid_q       <= INST_ID;
            araddr_q     <= map_addr(inst_addr);
            arsize_q     <= 3'd2;
            state_q      <= RD_ADDR;
          end else begin
            state_q <= IDLE;
          end
        end

        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end else begin
            state_q <= RD_ADDR;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            if (owner_data_q) begin
              data_rdata_q <= rdata;
              data_done_q  <= 1'b1;
            end else begin
              inst_rdata_q <= rdata;
              inst_done_q  <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            state_q <= RD_DATA;
          end
        end

        WR_ADDRDATA: begin
          // AW and W complete independently; a channel already done counts
          // as complete so both may also finish on the same edge.
          if (awready) begin
            awvalid_q <= 1'b0;
          end
          if (wready) begin
            wvalid_q <= 1'b0;
          end
          if ((awready || !awvalid_q) && (wready || !wvalid_q)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end else begin
            state_q <= WR_ADDRDATA;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            data_done_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= WR_RESP;
          end
        end

        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign inst_stall = inst_req & ~inst_done_q;
  assign data_stall = data_req & ~data_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = awid_q;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Response IDs/status are not used: ownership comes from the latched state.
  logic unused_s;
  assign unused_s = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
module tb_sramlike_axi_bridge;

  logic        clk;
  logic        rst;
  logic        longest_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst), .longest_stall(longest_stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_stall(data_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ax_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
  } vec_t;

  // scoreboard queues: expected AXI requests, pushed when stimulus is driven
  ax_t exp_ar[$];
  ax_t exp_aw[$];
  w_t  exp_w[$];

  int n_checks = 0;
  int n_fail   = 0;

  // slave knobs and bookkeeping
  int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int viol = 0;
  logic ar_wait = 1'b0, aw_wait = 1'b0, w_wait = 1'b0;
  ax_t ar_hold, aw_hold;
  w_t  w_hold;
  logic [31:0] r_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h3C08_0001;
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // AXI slave model: decisions at negedge, handshakes complete at next posedge
  initial begin
    ax_t e;
    w_t  f;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rid = 4'd0; rresp = 2'd0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        r_q.delete();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
        b_hs = (aw_hs < w_hs) ? aw_hs : w_hs;
      end else begin
        // valid must stay up with stable payload until its handshake
        if (ar_wait && (arvalid !== 1'b1 || arid !== ar_hold.id || araddr !== ar_hold.addr
                        || arsize !== ar_hold.size)) viol++;
        if (aw_wait && (awvalid !== 1'b1 || awid !== aw_hold.id || awaddr !== aw_hold.addr
                        || awsize !== aw_hold.size)) viol++;
        if (w_wait && (wvalid !== 1'b1 || wdata !== w_hold.data || wstrb !== w_hold.strb)) viol++;

        // AR
        if (arvalid === 1'b1) begin
          if (ar_cnt >= ar_delay) begin
            arready = 1'b1; ar_cnt = 0; ar_wait = 1'b0; ar_hs++;
            if (exp_ar.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL ar_unexpected: got id=%0h addr=0x%08h, expected no request", arid, araddr);
            end else begin
              e = exp_ar.pop_front();
              check32("ar_id", {28'd0, arid}, {28'd0, e.id});
              check32("ar_addr", araddr, e.addr);
              check32("ar_size", {29'd0, arsize}, {29'd0, e.size});
            end
            r_q.push_back(mem_fn(araddr));
          end else begin
            arready = 1'b0; ar_cnt++; ar_wait = 1'b1;
            ar_hold.id = arid; ar_hold.addr = araddr; ar_hold.size = arsize;
          end
        end else begin
          arready = 1'b0; ar_wait = 1'b0;
        end

        // R
        if (r_q.size() > 0 && rready === 1'b1) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1'b1; rdata = r_q.pop_front(); rlast = 1'b1; r_cnt = 0;
          end else begin
            rvalid = 1'b0; r_cnt++;
          end
        end else begin
          rvalid = 1'b0;
        end

        // AW
        if (awvalid === 1'b1) begin
          if (aw_cnt >= aw_delay) begin
            awready = 1'b1; aw_cnt = 0; aw_wait = 1'b0; aw_hs++;
            if (exp_aw.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL aw_unexpected: got addr=0x%08h, expected no request", awaddr);
            end else begin
              e = exp_aw.pop_front();
              check32("aw_id", {28'd0, awid}, {28'd0, e.id});
              check32("aw_addr", awaddr, e.addr);
              check32("aw_size", {29'd0, awsize}, {29'd0, e.size});
            end
          end else begin
            awready = 1'b0; aw_cnt++; aw_wait = 1'b1;
            aw_hold.id = awid; aw_hold.addr = awaddr; aw_hold.size = awsize;
          end
        end else begin
          awready = 1'b0; aw_wait = 1'b0;
        end

        // W
        if (wvalid === 1'b1) begin
          if (w_cnt >= w_delay) begin
            wready = 1'b1; w_cnt = 0; w_wait = 1'b0; w_hs++;
            if (exp_w.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL w_unexpected: got data=0x%08h, expected no beat", wdata);
            end else begin
              f = exp_w.pop_front();
              check32("w_data", wdata, f.data);
              check32("w_strb", {28'd0, wstrb}, {28'd0, f.strb});
              check32("w_last", {31'd0, wlast}, 32'd1);
            end
          end else begin
            wready = 1'b0; w_cnt++; w_wait = 1'b1;
            w_hold.data = wdata; w_hold.strb = wstrb;
          end
        end else begin
          wready = 1'b0; w_wait = 1'b0;
        end

        // B: bready before both AW and W completed is a protocol error
        if (bready === 1'b1) begin
          if (aw_hs <= b_hs || w_hs <= b_hs) viol++;
          if (b_hs < aw_hs && b_hs < w_hs) begin
            bvalid = 1'b1; b_hs++;
          end else begin
            bvalid = 1'b0;
          end
        end else begin
          bvalid = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_pipe();
    inst_req = 1'b0;
    data_req = 1'b0;
    longest_stall = 1'b0;
    step();
    longest_stall = 1'b1;
  endtask

  // Counts sampled cycles with the stall high; cyc==budget means timeout.
  task automatic wait_low(input bit is_data, input int budget, output int cyc);
    cyc = 0;
    #1;
    while ((is_data ? data_stall : inst_stall) && cyc < budget) begin
      cyc++;
      step();
      #1;
    end
    n_checks++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: stall high after %0d cycles, expected low", is_data ? "data" : "inst", cyc);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int c, dfall, ifall, wv, av, bad, snap, b_before;

    vecs[0] = '{1'b1, 2'd0, 32'hA000_0003, 32'hAB00_0000, 32'h0000_0003, 3'd0, 4'b1000};
    vecs[1] = '{1'b1, 2'd0, 32'h8000_0010, 32'h0000_0055, 32'h0000_0010, 3'd0, 4'b0001};
    vecs[2] = '{1'b1, 2'd0, 32'h0000_0101, 32'h0000_6600, 32'h0000_0101, 3'd0, 4'b0010};
    vecs[3] = '{1'b1, 2'd1, 32'h8000_0402, 32'h1234_0000, 32'h0000_0402, 3'd1, 4'b1100};
    vecs[4] = '{1'b1, 2'd1, 32'h4000_0000, 32'h0000_BEEF, 32'h4000_0000, 3'd1, 4'b0011};
    vecs[5] = '{1'b1, 2'd2, 32'hC000_0008, 32'h0BAD_F00D, 32'hC000_0008, 3'd2, 4'b1111};
    vecs[6] = '{1'b1, 2'd3, 32'h9FFF_FFFC, 32'h7777_8888, 32'h1FFF_FFFC, 3'd2, 4'b1111};
    vecs[7] = '{1'b0, 2'd1, 32'h8000_0006, 32'd0,         32'h0000_0006, 3'd1, 4'b0000};
    vecs[8] = '{1'b0, 2'd0, 32'h1000_0001, 32'd0,         32'h1000_0001, 3'd0, 4'b0000};

    rst = 1'b0; longest_stall = 1'b1;
    inst_req = 1'b1; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    repeat (3) step();
    #1;
    // reset state
    check32("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check32("rst_inst_stall", {31'd0, inst_stall}, 32'd1);
    check32("rst_data_stall", {31'd0, data_stall}, 32'd0);
    check32("rst_inst_rdata", inst_rdata, 32'd0);
    check32("rst_data_rdata", data_rdata, 32'd0);
    check32("rst_araddr", araddr, 32'd0);
    check32("rst_arid", {28'd0, arid}, 32'd0);
    check32("const_ar", {22'd0, arlen, arburst}, 32'h1);
    check32("const_aw", {21'd0, awlen, awburst, wlast}, 32'h3);
    inst_req = 1'b0; rst = 1'b1;
    step();

    // fetch from kseg1 with a zero-wait slave; done must win over the clear
    longest_stall = 1'b0;
    exp_ar.push_back('{4'd0, 32'h1FC0_0000, 3'd2});
    inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
    wait_low(1'b0, 20, c);
    check32("fetch_stall_cycles", c, 32'd3);
    check32("fetch_rdata", inst_rdata, 32'h3C08_0001);
    release_pipe();

    // simultaneous requests: data wins
    exp_ar.push_back('{4'd1, 32'h0000_1004, 3'd2});
    exp_ar.push_back('{4'd0, 32'h1FC0_0004, 3'd2});
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1004;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    dfall = -1; ifall = -1;
    #1;
    for (int i = 0; i < 30 && (dfall < 0 || ifall < 0); i++) begin
      if (dfall < 0 && !data_stall) dfall = i;
      if (ifall < 0 && !inst_stall) ifall = i;
      if (dfall < 0 || ifall < 0) begin step(); #1; end
    end
    check32("prio_data_fall", dfall, 32'd3);
    check32("prio_inst_fall", ifall, 32'd6);
    check32("prio_data_rdata", data_rdata, mem_fn(32'h0000_1004));
    check32("prio_inst_rdata", inst_rdata, mem_fn(32'h1FC0_0004));
    release_pipe();

    // table of data-port vectors
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        exp_aw.push_back('{4'd1, vecs[i].exp_addr, vecs[i].exp_size});
        exp_w.push_back('{vecs[i].wdat, vecs[i].exp_strb});
      end else begin
        exp_ar.push_back('{4'd1, vecs[i].exp_addr, vecs[i].exp_size});
      end
      b_before = b_hs;
      data_req = 1'b1; data_wr = vecs[i].wr; data_size = vecs[i].size;
      data_addr = vecs[i].addr; data_wdata = vecs[i].wdat;
      wait_low(1'b1, 20, c);
      if (vecs[i].wr) check32("vec_b_before_done", b_hs, b_before + 1);
      else            check32("vec_load_rdata", data_rdata, mem_fn(vecs[i].exp_addr));
      release_pipe();
    end

    // write with immediate wready and awready delayed 4 cycles
    aw_delay = 4; w_delay = 0;
    exp_aw.push_back('{4'd1, 32'h0000_0020, 3'd2});
    exp_w.push_back('{32'h1234_5678, 4'b1111});
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0020; data_wdata = 32'h1234_5678;
    wv = 0; av = 0; c = 0;
    #1;
    while (data_stall && c < 30) begin
      if (wvalid) wv++;
      if (awvalid) av++;
      c++; step(); #1;
    end
    check32("split_timeout", {31'd0, data_stall}, 32'd0);
    check32("split_wvalid_cycles", wv, 32'd1);
    check32("split_awvalid_cycles", av, 32'd5);
    release_pipe();
    aw_delay = 0;

    // fetch finishes while a slow store is pending under longest_stall
    exp_ar.push_back('{4'd0, 32'h1FC0_0008, 3'd2});
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    step();
    aw_delay = 6;
    exp_aw.push_back('{4'd1, 32'h0000_0040, 3'd2});
    exp_w.push_back('{32'hCAFE_F00D, 4'b1111});
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0040; data_wdata = 32'hCAFE_F00D;
    wait_low(1'b0, 20, c);
    snap = ar_hs; bad = 0;
    wait_low(1'b1, 40, c);
    check32("hold_ar_count", ar_hs, snap);
    // inst side while the store was pending was re-sampled below
    check32("hold_inst_rdata", inst_rdata, mem_fn(32'h1FC0_0008));
    check32("hold_inst_stall", {31'd0, inst_stall}, 32'd0);
    data_req = 1'b0; longest_stall = 1'b0;
    step();
    longest_stall = 1'b1;
    #1;
    check32("clear_inst_stall", {31'd0, inst_stall}, 32'd1);
    check32("clear_data_stall", {31'd0, data_stall}, 32'd0);
    exp_ar.push_back('{4'd0, 32'h1FC0_0008, 3'd2});
    wait_low(1'b0, 20, c);
    check32("refetch_rdata", inst_rdata, mem_fn(32'h1FC0_0008));
    release_pipe();
    aw_delay = 0;

    // inst stall and rdata sampled every cycle while a store is pending
    exp_ar.push_back('{4'd0, 32'h0000_0300, 3'd2});
    inst_req = 1'b1; inst_addr = 32'h8000_0300;
    step();
    aw_delay = 5;
    exp_aw.push_back('{4'd1, 32'h0000_0044, 3'd2});
    exp_w.push_back('{32'h0101_0202, 4'b1111});
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0044; data_wdata = 32'h0101_0202;
    wait_low(1'b0, 20, c);
    c = 0; bad = 0;
    while (data_stall && c < 40) begin
      if (inst_stall !== 1'b0 || inst_rdata !== mem_fn(32'h0000_0300)) bad++;
      c++; step(); #1;
    end
    check32("pending_inst_bad_cycles", bad, 32'd0);
    check32("pending_timeout", {31'd0, data_stall}, 32'd0);
    release_pipe();
    aw_delay = 0;

    // reset while waiting in RD_DATA
    r_delay = 5;
    exp_ar.push_back('{4'd0, 32'h1FC0_0010, 3'd2});
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    c = 0;
    #1;
    while (!rready && c < 20) begin c++; step(); #1; end
    check32("rdwait_rready", {31'd0, rready}, 32'd1);
    rst = 1'b0;
    step();
    #1;
    check32("midrst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check32("midrst_inst_stall", {31'd0, inst_stall}, {31'd0, inst_req});
    check32("midrst_data_stall", {31'd0, data_stall}, {31'd0, data_req});
    check32("midrst_inst_rdata", inst_rdata, 32'd0);
    check32("midrst_data_rdata", data_rdata, 32'd0);
    rst = 1'b1; inst_req = 1'b0; r_delay = 0;
    repeat (3) step();

    check32("protocol_violations", viol, 32'd0);
    check32("ar_left", exp_ar.size(), 32'd0);
    check32("aw_left", exp_aw.size(), 32'd0);
    check32("w_left", exp_w.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
